// File: rtl/log_expand.sv
// log_expand: streaming antilog. Converts 8-bit log2 codes {e[4:0], f[2:0]}
// into 32-bit linear estimates through a two-stage valid/ready pipeline.
// It also tags each beat with its bin index, counts frames and flags framing errors.
module log_expand #(
  parameter int unsigned NUM_BINS     = 512,
  parameter bit          ZERO_IS_ZERO = 1'b1,
  localparam int unsigned BIN_W       = $clog2(NUM_BINS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       log_in,
  input  logic             log_valid,
  input  logic             log_last,
  output logic             log_ready,
  output logic [31:0]      lin_out,
  output logic [BIN_W-1:0] lin_bin,
  output logic             lin_valid,
  output logic             lin_last,
  input  logic             lin_ready,
  output logic [15:0]      frame_count,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int unsigned FC_W     = 16;
  localparam int unsigned LIN_W    = 32;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [4:0]       s1_e_q, s1_e_d;
  logic [2:0]       s1_f_q, s1_f_d;
  logic             s1_zero_q, s1_zero_d;
  logic [BIN_W-1:0] s1_bin_q, s1_bin_d;
  logic             s1_last_q, s1_last_d;

  // Stage 2 (output) registers
  logic             lin_valid_q, lin_valid_d;
  logic [LIN_W-1:0] lin_out_q, lin_out_d;
  logic [BIN_W-1:0] lin_bin_q, lin_bin_d;
  logic             lin_last_q, lin_last_d;

  // Input-side frame tracking
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [FC_W-1:0]  frame_count_q, frame_count_d;
  logic             frame_err_q, frame_err_d;

  logic             ce_c;
  logic             accept_c;
  logic             bin_at_end_c;
  logic             err_set_c;
  logic [LIN_W-1:0] mant_c;
  logic [LIN_W-1:0] lin_c;

  assign ce_c         = !lin_valid_q || lin_ready;
  assign accept_c     = log_valid && ce_c;
  assign bin_at_end_c = (bin_q == LAST_BIN);

  assign log_ready   = ce_c;
  assign lin_out     = lin_out_q;
  assign lin_bin     = lin_bin_q;
  assign lin_valid   = lin_valid_q;
  assign lin_last    = lin_last_q;
  assign frame_count = frame_count_q;
  assign frame_err   = frame_err_q;

  // Antilog of the stage-1 code: place {1,f} at the top and shift down by 31-e
  always_comb begin
    mant_c = {1'b1, s1_f_q, 28'd0};
    lin_c  = mant_c >> (5'd31 - s1_e_q);
    if (ZERO_IS_ZERO && s1_zero_q) begin
      lin_c = '0;
    end
  end

  // Pipeline next state: both stages advance together on ce, otherwise hold
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_e_d      = s1_e_q;
    s1_f_d      = s1_f_q;
    s1_zero_d   = s1_zero_q;
    s1_bin_d    = s1_bin_q;
    s1_last_d   = s1_last_q;
    lin_valid_d = lin_valid_q;
    lin_out_d   = lin_out_q;
    lin_bin_d   = lin_bin_q;
    lin_last_d  = lin_last_q;
    if (ce_c) begin
      s1_valid_d  = log_valid;
      s1_e_d      = log_in[7:3];
      s1_f_d      = log_in[2:0];
      s1_zero_d   = (log_in == 8'h00);
      s1_bin_d    = bin_q;
      s1_last_d   = log_last;
      lin_valid_d = s1_valid_q;
      lin_out_d   = lin_c;
      lin_bin_d   = s1_bin_q;
      lin_last_d  = s1_last_q;
    end
  end

  // Bin counter, frame counter and sticky error; error set wins over clear
  always_comb begin
    bin_d         = bin_q;
    frame_count_d = frame_count_q;
    err_set_c     = 1'b0;
    if (accept_c) begin
      if (log_last) begin
        bin_d         = '0;
        frame_count_d = frame_count_q + FC_W'(1);
        err_set_c     = !bin_at_end_c;
      end else if (bin_at_end_c) begin
        bin_d     = '0;
        err_set_c = 1'b1;
      end else begin
        bin_d = bin_q + BIN_W'(1);
      end
    end
    if (err_set_c) begin
      frame_err_d = 1'b1;
    end else if (clr_err) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_e_q        <= '0;
      s1_f_q        <= '0;
      s1_zero_q     <= 1'b0;
      s1_bin_q      <= '0;
      s1_last_q     <= 1'b0;
      lin_valid_q   <= 1'b0;
      lin_out_q     <= '0;
      lin_bin_q     <= '0;
      lin_last_q    <= 1'b0;
      bin_q         <= '0;
      frame_count_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_e_q        <= s1_e_d;
      s1_f_q        <= s1_f_d;
      s1_zero_q     <= s1_zero_d;
      s1_bin_q      <= s1_bin_d;
      s1_last_q     <= s1_last_d;
      lin_valid_q   <= lin_valid_d;
      lin_out_q     <= lin_out_d;
      lin_bin_q     <= lin_bin_d;
      lin_last_q    <= lin_last_d;
      bin_q         <= bin_d;
      frame_count_q <= frame_count_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_log_expand.sv
// Bench for log_expand: two instances (zero maps to 0 / zero maps to 1) share one
// stimulus stream; a scoreboard queue and arithmetic antilog model give expectations.
module tb_log_expand;

  localparam int unsigned NB = 8;
  localparam int unsigned BW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    log_in;
  logic          log_valid;
  logic          log_last;
  logic          lin_ready = 1'b1;
  logic          clr_err;

  logic          log_ready,   log_ready_z;
  logic [31:0]   lin_out,     lin_out_z;
  logic [BW-1:0] lin_bin,     lin_bin_z;
  logic          lin_valid,   lin_valid_z;
  logic          lin_last,    lin_last_z;
  logic [15:0]   frame_count, frame_count_z;
  logic          frame_err,   frame_err_z;

  log_expand #(.NUM_BINS(NB), .ZERO_IS_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .log_in(log_in), .log_valid(log_valid), .log_last(log_last),
    .log_ready(log_ready), .lin_out(lin_out), .lin_bin(lin_bin), .lin_valid(lin_valid),
    .lin_last(lin_last), .lin_ready(lin_ready), .frame_count(frame_count),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  log_expand #(.NUM_BINS(NB), .ZERO_IS_ZERO(1'b0)) dut_z (
    .clk(clk), .rst(rst), .log_in(log_in), .log_valid(log_valid), .log_last(log_last),
    .log_ready(log_ready_z), .lin_out(lin_out_z), .lin_bin(lin_bin_z), .lin_valid(lin_valid_z),
    .lin_last(lin_last_z), .lin_ready(lin_ready), .frame_count(frame_count_z),
    .frame_err(frame_err_z), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   lin1;
    logic [31:0]   lin0;
    logic [BW-1:0] bin;
    logic          last;
    int            acc_cyc;
    int            stalls;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            stall_cnt = 0;
  int            rdy_mode = 0;
  logic [BW-1:0] m_bin = '0;
  logic [15:0]   m_fc = '0;
  logic          m_err = 1'b0;
  logic          prev_stall = 1'b0;
  logic [31:0]   s_out;
  logic [BW-1:0] s_bin;
  logic [7:0]    dir_codes [8] = '{8'h00, 8'h08, 8'h18, 8'h1F, 8'h3B, 8'hFF, 8'h07, 8'h0D};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Linear value = 2^e * (1 + f/8), fractional part dropped
  function automatic logic [31:0] ref_lin(input logic [7:0] c, input bit zero_is_zero);
    logic [63:0] m;
    if (zero_is_zero && c == 8'h00) return 32'd0;
    m = 64'(c[2:0]) + 64'd8;
    m = (m << c[7:3]) >> 3;
    return 32'(m);
  endfunction

  // Downstream ready: always, random, or held low
  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       lin_ready = 1'b1;
      1:       lin_ready = ($urandom_range(0, 3) != 0);
      default: lin_ready = 1'b0;
    endcase
  end

  // Monitor: checks state settled after the last edge, then predicts the next edge
  always @(negedge clk) begin
    exp_t e;
    exp_t ne;
    int   lat;
    logic set;
    if (rst) begin
      sb.delete();
      m_bin = '0;
      m_fc = '0;
      m_err = 1'b0;
      prev_stall = 1'b0;
    end else begin
      cyc++;
      check_eq("log_ready", 64'(log_ready), 64'(!lin_valid || lin_ready));
      check_eq("log_ready_z", 64'(log_ready_z), 64'(!lin_valid_z || lin_ready));
      check_eq("frame_count", 64'(frame_count), 64'(m_fc));
      check_eq("frame_count_z", 64'(frame_count_z), 64'(m_fc));
      check_eq("frame_err", 64'(frame_err), 64'(m_err));
      check_eq("frame_err_z", 64'(frame_err_z), 64'(m_err));
      if (prev_stall) begin
        check_eq("hold_valid", 64'(lin_valid), 64'd1);
        check_eq("hold_out", 64'(lin_out), 64'(s_out));
        check_eq("hold_bin", 64'(lin_bin), 64'(s_bin));
      end
      prev_stall = lin_valid && !lin_ready;
      s_out = lin_out;
      s_bin = lin_bin;
      if (lin_valid && lin_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'(lin_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("lin_out", 64'(lin_out), 64'(e.lin1));
          check_eq("lin_out_z", 64'(lin_out_z), 64'(e.lin0));
          check_eq("lin_valid_z", 64'(lin_valid_z), 64'd1);
          check_eq("lin_bin", 64'(lin_bin), 64'(e.bin));
          check_eq("lin_bin_z", 64'(lin_bin_z), 64'(e.bin));
          check_eq("lin_last", 64'(lin_last), 64'(e.last));
          check_eq("lin_last_z", 64'(lin_last_z), 64'(e.last));
          lat = cyc - e.acc_cyc;
          if (e.stalls == stall_cnt) check_eq("latency", 64'(lat), 64'd2);
          else                       check_eq("latency_min", 64'(lat >= 2), 64'd1);
        end
      end
      set = 1'b0;
      if (log_valid && log_ready) begin
        ne.lin1    = ref_lin(log_in, 1'b1);
        ne.lin0    = ref_lin(log_in, 1'b0);
        ne.bin     = m_bin;
        ne.last    = log_last;
        ne.acc_cyc = cyc;
        ne.stalls  = stall_cnt;
        sb.push_back(ne);
        if (log_last) begin
          set = (m_bin != BW'(NB - 1));
          m_bin = '0;
          m_fc = m_fc + 16'd1;
        end else if (m_bin == BW'(NB - 1)) begin
          set = 1'b1;
          m_bin = '0;
        end else begin
          m_bin = m_bin + BW'(1);
        end
      end
      if (set) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      if (!lin_ready) stall_cnt++;
    end
  end

  // Present one beat and hold it until accepted
  task automatic send(input logic [7:0] c, input logic l);
    int n = 0;
    log_valid = 1'b1;
    log_in = c;
    log_last = l;
    forever begin
      @(negedge clk);
      if (log_ready) break;
      n++;
      if (n > 200) begin
        check_eq("accept_timeout", 64'(log_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    log_valid = 1'b0;
    log_last = 1'b0;
  endtask

  task automatic idle(input int n);
    log_valid = 1'b0;
    log_last = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    log_valid = 1'b0;
    log_in = 8'h00;
    log_last = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(lin_valid), 64'd0);
    check_eq("rst_out", 64'(lin_out), 64'd0);
    check_eq("rst_bin", 64'(lin_bin), 64'd0);
    check_eq("rst_last", 64'(lin_last), 64'd0);
    check_eq("rst_fc", 64'(frame_count), 64'd0);
    check_eq("rst_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    idle(1);

    // Directed codes in one correct frame, then a second correct frame
    for (int i = 0; i < 8; i++) send(dir_codes[i], i == 7);
    send(8'h17, 1'b0);
    for (int i = 1; i < 8; i++) send(8'($urandom), i == 7);
    idle(4);
    check_eq("two_frames_fc", 64'(frame_count), 64'd2);
    check_eq("two_frames_err", 64'(frame_err), 64'd0);

    // Ten back-to-back beats with downstream held off mid-stream
    fork
      for (int i = 0; i < 10; i++) send(8'($urandom), i == 7);
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    for (int i = 2; i < 8; i++) send(8'($urandom), i == 7);
    idle(4);

    // Early last on beat 4, then a frame missing its last, then a good frame
    for (int i = 0; i < 5; i++) send(8'($urandom), i == 4);
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) send(8'($urandom), i == 7);
    idle(2);
    check_eq("err_sticky", 64'(frame_err), 64'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    check_eq("err_cleared", 64'(frame_err), 64'd0);
    send(8'($urandom), 1'b0);
    clr_err = 1'b1;
    send(8'($urandom), 1'b1);
    clr_err = 1'b0;
    idle(1);
    check_eq("err_set_beats_clr", 64'(frame_err), 64'd1);

    // Reset mid-frame with the output stalled
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    rdy_mode = 2;
    idle(4);
    check_eq("stalled_valid", 64'(lin_valid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(lin_valid), 64'd0);
    check_eq("arst_valid_z", 64'(lin_valid_z), 64'd0);
    check_eq("arst_fc", 64'(frame_count), 64'd0);
    check_eq("arst_err", 64'(frame_err), 64'd0);
    check_eq("arst_bin", 64'(lin_bin), 64'd0);
    rdy_mode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 8; i++) send(8'($urandom), i == 7);
    idle(4);

    // Randomised traffic with random backpressure, framing slips and clears
    rdy_mode = 1;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      logic l;
      if ($urandom_range(0, 3) == 0) idle(1);
      l = ($urandom_range(0, 15) == 0) || ((k % 8) == 7 && $urandom_range(0, 9) != 0);
      clr_err = ($urandom_range(0, 29) == 0);
      send(8'($urandom), l);
      clr_err = 1'b0;
      k = l ? 0 : k + 1;
    end

    // Drain
    rdy_mode = 0;
    idle(1);
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
    check_eq("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
